// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 32;

  // Iteration counter must hold the values 0..width.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift remainder, trial-subtract divisor, emit quotient bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to register the result.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] qr,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   pr_next,
  output logic [WIDTH-1:0] qr_next
);

  // Shifted remainder carries one spare bit so the compare never wraps.
  logic [WIDTH+1:0] sh;
  logic             ge;

  assign sh      = {pr, qr[WIDTH-1]};
  assign ge      = (sh >= {2'b00, dvsr});
  assign pr_next = ge ? (WIDTH+1)'(sh - {2'b00, dvsr}) : sh[WIDTH:0];
  assign qr_next = {qr[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (quotient/remainder); signed mode under SEQ_DIVIDER_SIGNED_EN.
// Latency: out_valid after edge WIDTH+1 from acceptance (after edge 1 for divide by zero).
// Backpressure: result held stable until out_ready; in_ready is a registered idle decode.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] qr_nxt;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Magnitudes feed the unsigned core; signs are re-applied when the result is loaded.
  assign x_mag = (sgn && X[WIDTH-1]) ? -X : X;
  assign y_mag = (sgn && Y[WIDTH-1]) ? -Y : Y;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .pr     (pr),
    .qr     (qr),
    .dvsr   (dvsr),
    .pr_next(pr_nxt),
    .qr_next(qr_nxt)
  );

  // Control FSM and datapath: accept, iterate WIDTH steps, then present the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      pr          <= '0;
      qr          <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pr       <= '0;
            qr       <= x_mag;
            dvsr     <= y_mag;
            cnt      <= '0;
            neg_q    <= sgn && (X[WIDTH-1] ^ Y[WIDTH-1]);
            neg_r    <= sgn && X[WIDTH-1];
            in_ready <= 1'b0;
            if (Y == '0) begin
              // Nothing to iterate: result is known at acceptance.
              state       <= DONE;
              quotient    <= '1;
              remainder   <= X;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          pr  <= pr_nxt;
          qr  <= qr_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last step: load the result with sign fix-up on the way out.
            state     <= DONE;
            quotient  <= neg_q ? -qr_nxt : qr_nxt;
            remainder <= neg_r ? -pr_nxt[WIDTH-1:0] : pr_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          // out_valid is registered one edge after the result is loaded.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
